// File: rtl/vga_fb_pkg.sv
// Shared geometry, colour constants and helpers for the blocked-pixel
// framebuffer and its writers.
package vga_fb_pkg;

  localparam int H_PIXELS   = 640;
  localparam int V_PIXELS   = 480;
  localparam int SCALE      = 20;
  localparam int DS_WIDTH   = H_PIXELS / SCALE;
  localparam int DS_HEIGHT  = V_PIXELS / SCALE;
  localparam int RAM_SIZE   = DS_WIDTH * DS_HEIGHT;
  localparam int ADDR_WIDTH = $clog2(RAM_SIZE);
  localparam int HW         = $clog2(DS_HEIGHT + 1);
  localparam int COL_W      = $clog2(DS_WIDTH);
  localparam int ROW_W      = $clog2(DS_HEIGHT + 1);
  localparam int IDX_W      = $clog2(DS_WIDTH + 1);

  localparam logic [7:0] BG_COLOR   = 8'h00;
  localparam logic [7:0] BAR_COLOR  = 8'h1C;
  localparam logic [7:0] PEAK_COLOR = 8'hE0;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} writer_state_t;

  function automatic logic [HW-1:0] sat_height(input logic [HW-1:0] h);
    return (h > HW'(DS_HEIGHT)) ? HW'(DS_HEIGHT) : h;
  endfunction

  // Bars grow upward from the bottom row; the topmost block of a bar is its cap.
  function automatic logic [7:0] block_colour(input logic [ROW_W-1:0] row,
                                              input logic [HW-1:0]    h);
    logic [HW-1:0] top;
    top = HW'(DS_HEIGHT) - h;
    if (h == '0 || HW'(row) < top) return BG_COLOR;
    else if (HW'(row) == top)      return PEAK_COLOR;
    else                           return BAR_COLOR;
  endfunction

endpackage

// File: rtl/bar_height_collector.sv
// Accepts per-column bar heights from the analyser stream into a shadow set
// and hands a consistent copy to the drawing side at start-of-frame.
module bar_height_collector
  import vga_fb_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sof_i,
  input  logic                         bar_valid_i,
  input  logic [HW-1:0]                bar_height_i,
  input  logic                         bar_last_i,
  output logic                         bar_ready_o,
  output logic [DS_WIDTH-1:0][HW-1:0]  draw_next_o
);

  logic [DS_WIDTH-1:0][HW-1:0] shadow_q;
  logic [DS_WIDTH-1:0][HW-1:0] draw_q;
  logic [IDX_W-1:0]            col_idx_q, col_idx_d;
  logic                        pending_q, pending_d;
  logic                        snapshot;
  logic                        in_range;

  // The stream never back-pressures; excess beats are simply dropped.
  assign bar_ready_o = 1'b1;
  assign snapshot    = sof_i && pending_q;
  assign in_range    = col_idx_q < IDX_W'(DS_WIDTH);

  // NOTE: every always_comb output gets a default first, otherwise paths that
  // skip an assignment infer a latch.
  always_comb begin
    col_idx_d = col_idx_q;
    pending_d = pending_q;
    if (snapshot) pending_d = 1'b0;
    // A bar_last beat landing with sof re-arms pending for the next frame.
    if (bar_valid_i) begin
      if (bar_last_i) begin
        col_idx_d = '0;
        pending_d = 1'b1;
      end else if (in_range) begin
        col_idx_d = col_idx_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so the
  // snapshot below copies shadow_q as it stood before this edge's beat.
  // NOTE: the height arrays are reset on purpose; a frame drawn before any
  // set arrives must be all background, not power-up garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      draw_q    <= '0;
      col_idx_q <= '0;
      pending_q <= 1'b0;
    end else begin
      col_idx_q <= col_idx_d;
      pending_q <= pending_d;
      if (snapshot) draw_q <= shadow_q;
      if (bar_valid_i && in_range)
        shadow_q[col_idx_q[COL_W-1:0]] <= sat_height(bar_height_i);
    end
  end

  // The first block of a sweep is emitted on the snapshot edge itself, so
  // the drawer needs the heights that draw_q is about to take.
  assign draw_next_o = snapshot ? shadow_q : draw_q;

endmodule

// File: rtl/spectrum_bar_writer.sv
// Fills the idle framebuffer with one block per address each frame: a
// row-major sweep colouring bar bodies, peak caps and background.
module spectrum_bar_writer
  import vga_fb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            hc,
  input  logic [9:0]            vc,
  input  logic                  bar_valid,
  output logic                  bar_ready,
  input  logic [HW-1:0]         bar_height,
  input  logic                  bar_last,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [7:0]            write_data,
  output logic                  write_en,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  logic                        sof;
  logic [DS_WIDTH-1:0][HW-1:0] draw_next;

  writer_state_t               state_q;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_sel, addr_d;
  logic [COL_W-1:0]            col_q, col_sel, col_d;
  logic [ROW_W-1:0]            row_q, row_sel, row_d;
  logic                        col_wrap;
  logic                        last_written;
  logic                        emit;
  logic [7:0]                  pixel;

  logic [ADDR_WIDTH-1:0]       write_addr_q;
  logic [7:0]                  write_data_q;
  logic                        write_en_q, busy_q, frame_done_q, overrun_q;

  assign sof = (hc == 10'd0) && (vc == 10'd0);

  bar_height_collector u_collector (
    .clk          (clk),
    .rst_n        (rst_n),
    .sof_i        (sof),
    .bar_valid_i  (bar_valid),
    .bar_height_i (bar_height),
    .bar_last_i   (bar_last),
    .bar_ready_o  (bar_ready),
    .draw_next_o  (draw_next)
  );

  // The counters point at the next block to emit; sof forces block 0.
  always_comb begin
    addr_sel     = sof ? '0 : addr_q;
    col_sel      = sof ? '0 : col_q;
    row_sel      = sof ? '0 : row_q;
    col_wrap     = (col_sel == COL_W'(DS_WIDTH - 1));
    addr_d       = addr_sel + 1'b1;
    col_d        = col_wrap ? '0 : col_sel + 1'b1;
    row_d        = col_wrap ? row_sel + 1'b1 : row_sel;
    last_written = (write_addr_q == ADDR_WIDTH'(RAM_SIZE - 1));
    emit         = sof || (state_q == DRAW && !last_written);
    pixel        = block_colour(row_sel, draw_next[col_sel]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      write_addr_q <= '0;
      write_data_q <= '0;
      write_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (sof && state_q == DRAW) overrun_q <= 1'b1;
      if (emit) begin
        state_q      <= DRAW;
        write_en_q   <= 1'b1;
        busy_q       <= 1'b1;
        write_addr_q <= addr_sel;
        write_data_q <= pixel;
        addr_q       <= addr_d;
        col_q        <= col_d;
        row_q        <= row_d;
      end else begin
        write_en_q <= 1'b0;
        busy_q     <= 1'b0;
        case (state_q)
          DRAW: begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign write_en   = write_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spectrum_bar_writer.sv
// Randomised bench for spectrum_bar_writer against a frame-level model of
// the height stream and the expected picture.
module tb_spectrum_bar_writer;
  import vga_fb_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [9:0]            hc = 10'd5;
  logic [9:0]            vc = 10'd5;
  logic                  bar_valid = 1'b0;
  logic [HW-1:0]         bar_height = '0;
  logic                  bar_last = 1'b0;
  logic                  bar_ready;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [7:0]            write_data;
  logic                  write_en, busy, frame_done, overrun;

  spectrum_bar_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hc         (hc),
    .vc         (vc),
    .bar_valid  (bar_valid),
    .bar_ready  (bar_ready),
    .bar_height (bar_height),
    .bar_last   (bar_last),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_en   (write_en),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: height sets and the picture they imply.
  int  m_shadow [DS_WIDTH];
  int  m_draw   [DS_WIDTH];
  int  m_idx;
  bit  m_pending;

  logic [7:0]            obs_frame [RAM_SIZE];
  logic                  obs_we, obs_busy, obs_fd, obs_ovr, obs_rdy;
  logic [ADDR_WIDTH-1:0] obs_addr;
  logic [7:0]            obs_data;

  function automatic void model_reset();
    for (int i = 0; i < DS_WIDTH; i++) begin
      m_shadow[i] = 0;
      m_draw[i]   = 0;
    end
    m_idx     = 0;
    m_pending = 1'b0;
  endfunction

  function automatic void model_edge(bit sof, bit valid, int h, bit last);
    if (sof && m_pending) begin
      m_draw    = m_shadow;
      m_pending = 1'b0;
    end
    if (valid) begin
      if (m_idx < DS_WIDTH) m_shadow[m_idx] = (h > DS_HEIGHT) ? DS_HEIGHT : h;
      if (last) begin
        m_idx     = 0;
        m_pending = 1'b1;
      end else if (m_idx < DS_WIDTH) begin
        m_idx++;
      end
    end
  endfunction

  function automatic logic [7:0] exp_colour(int a);
    int col = a % DS_WIDTH;
    int row = a / DS_WIDTH;
    int h   = m_draw[col];
    int top = DS_HEIGHT - h;
    if (h == 0 || row < top) return BG_COLOR;
    if (row == top)          return PEAK_COLOR;
    return BAR_COLOR;
  endfunction

  // One clock: drive inputs, sample outputs on the falling edge, then let
  // the model see the rising edge the DUT sees.
  task automatic step(input bit sof, input bit valid, input int h, input bit last);
    hc         = sof ? 10'd0 : 10'd5;
    vc         = sof ? 10'd0 : 10'd5;
    bar_valid  = valid;
    bar_height = HW'(h);
    bar_last   = last;
    @(negedge clk);
    obs_we   = write_en;
    obs_busy = busy;
    obs_fd   = frame_done;
    obs_ovr  = overrun;
    obs_rdy  = bar_ready;
    obs_addr = write_addr;
    obs_data = write_data;
    @(posedge clk);
    model_edge(sof, valid, h, last);
    #1;
    hc        = 10'd5;
    vc        = 10'd5;
    bar_valid = 1'b0;
    bar_last  = 1'b0;
  endtask

  task automatic send_set(input int heights[$], input int max_gap);
    for (int i = 0; i < heights.size(); i++) begin
      int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 0, 1'b0);
      step(1'b0, 1'b1, heights[i], i == heights.size() - 1);
    end
  endtask

  // Follows a sweep already started by an sof step.
  task automatic run_sweep(input string name, input int n, input bit check_end);
    for (int k = 0; k < n; k++) begin
      logic [7:0] exp;
      step(1'b0, 1'b0, 0, 1'b0);
      exp = exp_colour(k);
      obs_frame[k] = obs_data;
      vectors++;
      if (obs_we !== 1'b1 || obs_busy !== 1'b1 || obs_addr !== ADDR_WIDTH'(k) || obs_data !== exp) begin
        miscompares++;
        $display("FAIL %s write %0d: en=%b busy=%b addr=%0d data=%h, expected en=1 busy=1 addr=%0d data=%h",
                 name, k, obs_we, obs_busy, obs_addr, obs_data, k, exp);
      end
    end
    if (check_end) begin
      step(1'b0, 1'b0, 0, 1'b0);
      vectors++;
      if (obs_we !== 1'b0 || obs_busy !== 1'b0 || obs_fd !== 1'b1) begin
        miscompares++;
        $display("FAIL %s end: en=%b busy=%b frame_done=%b, expected en=0 busy=0 frame_done=1",
                 name, obs_we, obs_busy, obs_fd);
      end
      step(1'b0, 1'b0, 0, 1'b0);
      vectors++;
      if (obs_fd !== 1'b0 || obs_we !== 1'b0) begin
        miscompares++;
        $display("FAIL %s pulse: frame_done=%b en=%b, expected 0 0", name, obs_fd, obs_we);
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #23;
    vectors++;
    if (write_en !== 1'b0 || write_addr !== '0 || write_data !== 8'h00 || busy !== 1'b0 ||
        frame_done !== 1'b0 || overrun !== 1'b0 || bar_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: en=%b addr=%0d data=%h busy=%b fd=%b ovr=%b rdy=%b, expected 0 0 00 0 0 0 1",
               write_en, write_addr, write_data, busy, frame_done, overrun, bar_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_empty_frame();
    step(1'b1, 1'b0, 0, 1'b0);
    run_sweep("empty", RAM_SIZE, 1'b1);
    vectors++;
    if (obs_frame[RAM_SIZE-1] !== BG_COLOR || obs_frame[0] !== BG_COLOR) begin
      miscompares++;
      $display("FAIL empty_spot: got %h/%h, expected 00/00", obs_frame[0], obs_frame[RAM_SIZE-1]);
    end
  endtask

  task automatic test_uniform();
    int         hs[$];
    int         sa[6] = '{0, 575, 608, 639, 640, 767};
    logic [7:0] se[6] = '{BG_COLOR, BG_COLOR, PEAK_COLOR, PEAK_COLOR, BAR_COLOR, BAR_COLOR};
    for (int i = 0; i < DS_WIDTH; i++) hs.push_back(5);
    send_set(hs, 0);
    step(1'b1, 1'b0, 0, 1'b0);
    run_sweep("uniform", RAM_SIZE, 1'b1);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (obs_frame[sa[i]] !== se[i]) begin
        miscompares++;
        $display("FAIL uniform_spot addr %0d: got %h, expected %h", sa[i], obs_frame[sa[i]], se[i]);
      end
    end
  endtask

  task automatic test_saturate();
    int         hs[$] = '{24, 0, 30};
    int         sa[5] = '{0, 32, 1, 737, 2};
    logic [7:0] se[5] = '{PEAK_COLOR, BAR_COLOR, BG_COLOR, BG_COLOR, PEAK_COLOR};
    send_set(hs, 1);
    step(1'b1, 1'b0, 0, 1'b0);
    run_sweep("saturate", RAM_SIZE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (obs_frame[sa[i]] !== se[i]) begin
        miscompares++;
        $display("FAIL saturate_spot addr %0d: got %h, expected %h", sa[i], obs_frame[sa[i]], se[i]);
      end
    end
  endtask

  task automatic test_sof_with_last();
    int hs[$];
    for (int i = 0; i < DS_WIDTH; i++) hs.push_back(12);
    send_set(hs, 0);
    step(1'b1, 1'b0, 0, 1'b0);
    run_sweep("old_set", RAM_SIZE, 1'b1);
    for (int i = 0; i < DS_WIDTH - 1; i++) step(1'b0, 1'b1, 3, 1'b0);
    step(1'b1, 1'b1, 3, 1'b1);
    run_sweep("same_cycle", RAM_SIZE, 1'b1);
    vectors++;
    if (obs_frame[384] !== PEAK_COLOR) begin
      miscompares++;
      $display("FAIL same_cycle_old addr 384: got %h, expected %h", obs_frame[384], PEAK_COLOR);
    end
    step(1'b1, 1'b0, 0, 1'b0);
    run_sweep("deferred", RAM_SIZE, 1'b1);
    vectors++;
    if (obs_frame[384] !== BG_COLOR || obs_frame[672] !== PEAK_COLOR) begin
      miscompares++;
      $display("FAIL deferred_new addr 384/672: got %h/%h, expected %h/%h",
               obs_frame[384], obs_frame[672], BG_COLOR, PEAK_COLOR);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int hs[$];
      int n = int'($urandom_range(40, 1));
      for (int i = 0; i < n; i++) hs.push_back(int'($urandom_range(31, 0)));
      send_set(hs, 2);
      vectors++;
      if (obs_rdy !== 1'b1) begin
        miscompares++;
        $display("FAIL random_ready round %0d: got %b, expected 1", r, obs_rdy);
      end
      step(1'b1, 1'b0, 0, 1'b0);
      run_sweep("random", RAM_SIZE, 1'b1);
    end
  endtask

  task automatic test_overrun();
    step(1'b1, 1'b0, 0, 1'b0);
    run_sweep("pre_overrun", 100, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    vectors++;
    if (overrun !== 1'b1 || write_en !== 1'b1 || write_addr !== '0) begin
      miscompares++;
      $display("FAIL overrun_restart: ovr=%b en=%b addr=%0d, expected 1 1 0", overrun, write_en, write_addr);
    end
    run_sweep("post_overrun", RAM_SIZE, 1'b1);
    vectors++;
    if (obs_ovr !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_sticky: got %b, expected 1", obs_ovr);
    end
  endtask

  task automatic test_reset_mid_draw();
    step(1'b1, 1'b0, 0, 1'b0);
    run_sweep("pre_reset", 301, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (write_en !== 1'b0 || write_addr !== '0 || busy !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: en=%b addr=%0d busy=%b ovr=%b, expected 0 0 0 0",
               write_en, write_addr, busy, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 0, 1'b0);
      vectors++;
      if (obs_we !== 1'b0 || obs_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL after_reset cycle %0d: en=%b busy=%b, expected 0 0", i, obs_we, obs_busy);
      end
    end
    step(1'b1, 1'b0, 0, 1'b0);
    run_sweep("after_reset", RAM_SIZE, 1'b1);
    vectors++;
    if (obs_ovr !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset_overrun: got %b, expected 0", obs_ovr);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty_frame();
    test_uniform();
    test_saturate();
    test_sof_with_last();
    test_random();
    test_overrun();
    test_reset_mid_draw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spectrum_bar_writer.md
Name: spectrum_bar_writer

Overview:
- Producer side of the ping-pong framebuffer: the graphics controller that fills the idle (write) buffer each frame.
- Accepts one bar height per downscaled column from the audio analyser over a valid/ready stream.
- At start-of-frame it snapshots the heights, then sweeps every blocked-pixel address once. It drives write_addr/write_data/write_en with bar, peak-cap or background colours.

Parameters:
H_PIXELS, 640, active horizontal pixels
V_PIXELS, 480, active vertical pixels
SCALE, 20, blocking factor
DS_WIDTH, H_PIXELS/SCALE, columns (bars)
DS_HEIGHT, V_PIXELS/SCALE, rows
RAM_SIZE, DS_WIDTH*DS_HEIGHT, framebuffer words
ADDR_WIDTH, $clog2(RAM_SIZE), write address width
HW, $clog2(DS_HEIGHT+1), bar height width
BG_COLOR, 8'h00, background colour
BAR_COLOR, 8'h1C, bar body colour
PEAK_COLOR, 8'hE0, top block of each non-empty bar

Ports:
clk  in  1  pixel clock, shared with the framebuffer and VGA counters
rst_n  in  1  asynchronous active-low reset
hc  in  10  VGA horizontal counter
vc  in  10  VGA vertical counter
bar_valid  in  1  height beat valid
bar_ready  out  1  height beat accepted when valid&ready
bar_height  in  HW  bar height in blocks
bar_last  in  1  marks final beat of a height set
write_addr  out  ADDR_WIDTH  framebuffer write address
write_data  out  8  framebuffer pixel colour
write_en  out  1  framebuffer write strobe
busy  out  1  high while in DRAW
frame_done  out  1  one-cycle pulse after last write
overrun  out  1  sticky; set if start-of-frame arrives while in DRAW

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - write_addr=0, write_data=0, write_en=0, busy=0, frame_done=0, overrun=0, bar_ready=1.
  - Shadow and draw height arrays cleared to 0; pending=0; column index=0; state IDLE.
- Start-of-frame: sof = (hc==0 && vc==0), evaluated combinationally and sampled at the clock edge. The framebuffer swaps buffers on the same edge, so writes from the following cycle land in the new idle buffer.
- Height stream:
  - bar_ready is held at 1 at all times outside reset.
  - On each accepted beat: shadow[col_idx] <= min(bar_height, DS_HEIGHT), then col_idx increments.
  - Beats with col_idx >= DS_WIDTH are dropped, but bar_last is still honoured.
  - An accepted beat with bar_last=1 resets col_idx to 0 and sets pending=1.
  - A short set (fewer than DS_WIDTH beats) leaves the remaining columns at their old values.
- Snapshot: on sof, if pending then draw[] <= shadow[] and pending <= 0.
  - If a bar_last beat is accepted in the same cycle as sof, the snapshot uses shadow[] as it stood before that beat. pending is left at 1 for the next frame.
- States:
  - IDLE -> DRAW on sof.
  - DRAW -> DONE after the write of addr RAM_SIZE-1.
  - DONE -> IDLE unconditionally (1 cycle).
- DRAW sweep:
  - Row-major; registered counters addr, col, row. No multiplier.
  - col wraps at DS_WIDTH-1 to 0 and increments row; addr increments by 1.
- Colour per block, with h = draw[col] and top = DS_HEIGHT - h:
  - row < top -> BG_COLOR
  - row == top and h > 0 -> PEAK_COLOR
  - row > top -> BAR_COLOR
  - h = 0 gives an all-background column.
- Timing and outputs (all registered):
  - sof sampled at edge N: write_en is high on cycles N+1 .. N+RAM_SIZE, with write_addr 0 .. RAM_SIZE-1 and matching write_data.
  - busy is high on the same cycles as write_en.
  - frame_done pulses on cycle N+RAM_SIZE+1.
- sof during DRAW: set overrun, re-snapshot as above, restart the sweep at addr 0 on the next cycle.
- sof in DONE: treated as in IDLE.
- Reset mid-DRAW: outputs return to reset values immediately. No further writes occur until the next sof.

Decomposition:
- Package vga_fb_pkg holds H_PIXELS, V_PIXELS, SCALE, DS_WIDTH, DS_HEIGHT, RAM_SIZE, ADDR_WIDTH, the colour constants, and typedef enum {IDLE, DRAW, DONE} writer_state_t.
- One natural sub-module: bar_height_collector, containing the stream acceptance, shadow array, col_idx, pending flag and snapshot.

Test Plan:
- Reset then first sof, no heights loaded -> 768 writes, addr 0..767, all 8'h00; frame_done at sof+769; busy high exactly 768 cycles.
- Load 32 beats of height 5 with bar_last on beat 32, then sof:
  - addr 0..18*32-1 = BG.
  - Row 19 (addr 608..639) = PEAK 8'hE0.
  - Rows 20..23 = BAR 8'h1C.
- Load heights col0=24, col1=0, col2=30 (saturates to 24), then sof:
  - addr 0 = PEAK, addr 32 = BAR, addr 1 = BG, addr 737 = BG, addr 2 = PEAK.
- bar_last accepted in the same cycle as sof -> the frame draws the old heights. The next sof draws the new heights, with no second bar_last needed.
- Force hc=vc=0 again 100 cycles into DRAW -> overrun=1 and held; the write at the next cycle has addr 0; 768 further writes follow, then frame_done.
- Deassert rst_n at sweep addr 300 -> write_en=0 and addr=0 at once. After release, no writes occur until sof; overrun=0.
